// File: rtl/hwa_total.sv
// Stochastic-computing 4-tap FIR bank: one binary sample per 2**N-clock window,
// AND products and a 4:1 MUX sum per clock, per-window ones count added into a saturating total.

// 12-bit de Bruijn generator: maximal LFSR with the all-zero state spliced in,
// so every value 0..2**N-1 appears exactly once per 2**N steps.
module hwa_total_dbseq #(
  parameter int           N    = 12,
  parameter logic [N-1:0] TAPS = 12'h829,  // x^12+x^6+x^4+x+1
  parameter logic [N-1:0] SEED = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         reseed_i,
  input  logic         step_i,
  output logic [N-1:0] state_o
);
  logic [N-1:0] s_q, s_d;
  logic         fb;

  // Zero-detect on the low bits steers 100..0 -> 0 -> 0..01 instead of 100..0 -> 0..01.
  always_comb begin
    fb  = (^(s_q & TAPS)) ^ (s_q[N-2:0] == '0);
    s_d = {s_q[N-2:0], fb};
  end

  always_ff @(posedge clock) begin
    if (reset || reseed_i) s_q <= SEED;
    else if (step_i)       s_q <= s_d;
  end

  assign state_o = s_q;
endmodule

// One tap: unipolar SC multiply of sample and coefficient streams.
module hwa_total_tap #(
  parameter int N = 12
) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] c_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         p_o
);
  assign p_o = (x_i > a_i) & (c_i > b_i);
endmodule

module hwa_total #(
  parameter int           N      = 12,
  parameter int           OUT_W  = 4*N-5,
  parameter int           TAPS   = 4,
  parameter logic [N-1:0] C0     = 12'd1024,
  parameter logic [N-1:0] C1     = 12'd1024,
  parameter logic [N-1:0] C2     = 12'd1024,
  parameter logic [N-1:0] C3     = 12'd1024,
  parameter logic [N-1:0] SEED_A = 12'h001,
  parameter logic [N-1:0] SEED_B = 12'hACE,
  parameter logic [N-1:0] SEED_S = 12'h5A5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     in,
  output logic [OUT_W-1:0] out,
  output logic             out_valid
);
  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [TAPS-1:0][N-1:0] COEF = {C3, C2, C1, C0};

  state_e                   state_q;
  logic [N-1:0]             cnt_q;
  logic [N:0]               ones_q;
  logic [TAPS-1:0][N-1:0]   x_q;
  logic [OUT_W-1:0]         out_q;
  logic                     out_valid_q;

  logic [N-1:0]             gen_a, gen_b, gen_s;
  logic [TAPS-1:0]          p;
  logic                     y, run, win_end;
  logic [N:0]               win_cnt_d;
  logic [OUT_W:0]           sum_d;
  logic [OUT_W-1:0]         acc_d;
  logic                     unused_s;

  // A start pulse takes the edge over any counting, including a window end.
  assign run     = (state_q == RUN) && !start;
  assign win_end = run && (cnt_q == '1);

  hwa_total_dbseq #(.N(N), .SEED(SEED_A)) u_gen_a (
    .clock(clock), .reset(reset), .reseed_i(start), .step_i(run), .state_o(gen_a));
  hwa_total_dbseq #(.N(N), .SEED(SEED_B)) u_gen_b (
    .clock(clock), .reset(reset), .reseed_i(start), .step_i(run), .state_o(gen_b));
  hwa_total_dbseq #(.N(N), .SEED(SEED_S)) u_gen_s (
    .clock(clock), .reset(reset), .reseed_i(start), .step_i(run), .state_o(gen_s));

  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    hwa_total_tap #(.N(N)) u_tap (
      .x_i(x_q[i]), .c_i(COEF[i]), .a_i(gen_a), .b_i(gen_b), .p_o(p[i]));
  end

  assign y        = p[gen_s[1:0]];
  assign unused_s = ^gen_s[N-1:2];

  // Window total includes this cycle's bit; it can reach exactly 2**N.
  always_comb begin
    win_cnt_d = ones_q + {{N{1'b0}}, y};
    sum_d     = {1'b0, out_q} + {{(OUT_W-N){1'b0}}, win_cnt_d};
    acc_d     = sum_d[OUT_W] ? '1 : sum_d[OUT_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ones_q      <= '0;
      x_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (start) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      ones_q      <= '0;
      x_q         <= {{((TAPS-1)*N){1'b0}}, in};
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + 1'b1;
      if (win_end) begin
        out_q       <= acc_d;
        out_valid_q <= 1'b1;
        ones_q      <= '0;
        x_q         <= {x_q[TAPS-2:0], in};
      end else begin
        out_valid_q <= 1'b0;
        ones_q      <= win_cnt_d;
      end
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_hwa_total.sv
// Directed bench for hwa_total: three instances (default coefficients, full-scale
// coefficients, and full-scale with a 14-bit accumulator for saturation).
module tb_hwa_total;
  localparam int N   = 12;
  localparam int WIN = 4096;

  logic          clock = 1'b0;
  logic          reset;
  logic          start_d, start_f;
  logic [N-1:0]  in_d, in_f;
  logic [42:0]   out_d, out_f;
  logic [13:0]   out_s;
  logic          vld_d, vld_f, vld_s;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  hwa_total dut_d (
    .clock(clock), .reset(reset), .start(start_d), .in(in_d),
    .out(out_d), .out_valid(vld_d));

  hwa_total #(.C0(12'hFFF), .C1(12'hFFF), .C2(12'hFFF), .C3(12'hFFF)) dut_f (
    .clock(clock), .reset(reset), .start(start_f), .in(in_f),
    .out(out_f), .out_valid(vld_f));

  hwa_total #(.OUT_W(14), .C0(12'hFFF), .C1(12'hFFF), .C2(12'hFFF), .C3(12'hFFF)) dut_s (
    .clock(clock), .reset(reset), .start(start_f), .in(in_f),
    .out(out_s), .out_valid(vld_s));

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic rng(input string tag, input longint obs, input longint lo, input longint hi);
    tests++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_d(input logic [N-1:0] v);
    in_d = v; start_d = 1'b1;
    @(posedge clock); #1;
    start_d = 1'b0;
  endtask

  task automatic pulse_f(input logic [N-1:0] v);
    in_f = v; start_f = 1'b1;
    @(posedge clock); #1;
    start_f = 1'b0;
  endtask

  // Edges until out_valid, bounded so a dead DUT shows up as a period failure.
  task automatic wait_d(output int n);
    n = 0;
    do begin @(posedge clock); #1; n++; end while (vld_d !== 1'b1 && n < WIN + 200);
  endtask

  task automatic wait_f(output int n);
    n = 0;
    do begin @(posedge clock); #1; n++; end while (vld_f !== 1'b1 && n < WIN + 200);
  endtask

  initial begin
    int     n, bad, vcnt, sum;
    longint prev, lo_c, hi_c, cnt;
    int     hist [4];
    longint lo_t [4] = '{1022, 2046, 3070, 4094};
    longint hi_t [4] = '{1024, 2048, 3072, 4095};

    reset = 1'b1; start_d = 1'b0; start_f = 1'b0; in_d = '0; in_f = '0;
    tick(3);
    chk("rst_out_d", longint'(out_d), 0);
    chk("rst_vld_d", longint'(vld_d), 0);
    chk("rst_out_s", longint'(out_s), 0);
    reset = 1'b0;

    // Idle: nothing moves for 100 clocks
    bad = 0; vcnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (out_d !== '0 || out_f !== '0 || out_s !== '0) bad++;
      if ((vld_d | vld_f | vld_s) !== 1'b0) vcnt++;
    end
    chk("idle_out_nonzero", bad, 0);
    chk("idle_vld_pulses", vcnt, 0);

    // Zero input contributes exactly zero
    pulse_d('0);
    for (int w = 0; w < 3; w++) begin
      wait_d(n);
      chk("zero_period", n, WIN);
      chk("zero_out", longint'(out_d), 0);
    end

    // Reset mid-window drops the run: outputs clear, no further pulses
    pulse_f(12'hFFF);
    tick(2000);
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("midrst_out_f", longint'(out_f), 0);
    chk("midrst_out_s", longint'(out_s), 0);
    vcnt = 0;
    for (int i = 0; i < WIN + 100; i++) begin
      tick(1);
      if ((vld_d | vld_f | vld_s) !== 1'b0) vcnt++;
    end
    chk("midrst_vld_pulses", vcnt, 0);

    // Full-scale input and coefficients; the 14-bit copy must saturate, not wrap
    pulse_f(12'hFFF);
    prev = 0; lo_c = 0; hi_c = 0;
    for (int w = 0; w < 7; w++) begin
      wait_f(n);
      chk("fs_period", n, WIN);
      chk("fs_vld_s", longint'(vld_s), 1);
      cnt = longint'(out_f) - prev;
      rng("fs_count", cnt, lo_t[(w < 3) ? w : 3], hi_t[(w < 3) ? w : 3]);
      prev = longint'(out_f);
      lo_c += lo_t[(w < 3) ? w : 3];
      hi_c += hi_t[(w < 3) ? w : 3];
      if (lo_c >= 16383) chk("sat_out", longint'(out_s), 16383);
      else               rng("sat_cum", longint'(out_s), lo_c, hi_c);
    end

    // Ramp 3,7,11,... with default coefficients: ideal count = sum(x)/16
    reset = 1'b1; tick(1); reset = 1'b0;
    pulse_d(12'd3);
    hist = '{3, 0, 0, 0};
    in_d = 12'd7;
    prev = 0;
    for (int w = 0; w < 4; w++) begin
      wait_d(n);
      chk("ramp_period", n, WIN);
      rng("ramp_nondecr", longint'(out_d), prev, 64'h7FF_FFFF_FFFF);
      sum = hist[0] + hist[1] + hist[2] + hist[3];
      cnt = longint'(out_d) - prev;
      rng("ramp_count_x16", cnt * 16, (sum > 256) ? sum - 256 : 0, sum + 256);
      prev = longint'(out_d);
      hist = '{int'(in_d), hist[0], hist[1], hist[2]};
      in_d = in_d + 12'd4;
    end

    // Restart mid-window clears out; next pulse one full window later
    tick(1000);
    pulse_d(12'hFFF);
    chk("restart_out", longint'(out_d), 0);
    chk("restart_vld", longint'(vld_d), 0);
    wait_d(n);
    chk("restart_period", n, WIN);
    rng("restart_count", longint'(out_d), 0, 1024);

    // Start landing exactly on a window end: no accumulate, no pulse
    tick(WIN - 1);
    pulse_d(12'hFFF);
    chk("coinc_vld", longint'(vld_d), 0);
    chk("coinc_out", longint'(out_d), 0);
    wait_d(n);
    chk("coinc_period", n, WIN);
    rng("coinc_count", longint'(out_d), 0, 1024);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
